cdb_arbiter: RTL and testbench

Completion arbiter between the execute-stage functional units and the common data bus. Each cycle it accepts completed packets from ALU, load and multiplier outputs into small per-source buffers, selects one packet and broadcasts it on a registered CDB port. Buffered packets honour branch squash and branch resolution by branch mask. A full buffer stalls its producing unit.

---
 rtl/cdb_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - per-source completion buffers arbitrated onto a registered CDB
// Build option CDB_ARB_RR_EN selects round-robin grant; default is fixed priority MUL > LD > ALU.
module cdb_arbiter #(
    parameter int NUM_SRC = 3,
    parameter int DEPTH   = 2,
    parameter int XLEN    = 32,
    parameter int TAG_W   = 6,
    parameter int ROB_W   = 5,
    parameter int MASK_W  = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_SRC-1:0]        fu_valid,
    input  logic [NUM_SRC*XLEN-1:0]   fu_data,
    input  logic [NUM_SRC*TAG_W-1:0]  fu_tag,
    input  logic [NUM_SRC*ROB_W-1:0]  fu_rob_idx,
    input  logic [NUM_SRC*MASK_W-1:0] fu_mask,
    output logic [NUM_SRC-1:0]        fu_stall,
    input  logic                      squash_valid,
    input  logic [MASK_W-1:0]         squash_mask,
    input  logic                      resolve_valid,
    input  logic [MASK_W-1:0]         resolve_mask,
    output logic                      cdb_valid,
    output logic [XLEN-1:0]           cdb_data,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [ROB_W-1:0]          cdb_rob_idx,
    output logic [MASK_W-1:0]         cdb_mask,
    output logic [1:0]                cdb_src,
    output logic                      overflow
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0]   data;
        logic [TAG_W-1:0]  tag;
        logic [ROB_W-1:0]  rob;
        logic [MASK_W-1:0] mask;
    } pkt_t;

    pkt_t             buf_q [NUM_SRC][DEPTH];
    pkt_t             buf_d [NUM_SRC][DEPTH];
    logic [CNT_W-1:0] cnt_q [NUM_SRC];
    logic [CNT_W-1:0] cnt_d [NUM_SRC];
    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] gnt;
    logic [1:0]       gnt_idx;
    logic             any_gnt;
    logic             ovf_q, ovf_d;
    pkt_t             cdb_q, cdb_d;
    logic             cdb_vq;
    logic [1:0]       cdb_src_q;
    logic [MASK_W-1:0] keep_mask;

    function automatic logic killed(input logic sv, input logic [MASK_W-1:0] sm,
                                    input logic [MASK_W-1:0] m);
        return sv && (|(m & sm));
    endfunction

    assign keep_mask = resolve_valid ? ~resolve_mask : '1;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            cand[i]     = (cnt_q[i] != '0) && !killed(squash_valid, squash_mask, buf_q[i][0].mask);
            fu_stall[i] = (cnt_q[i] == CNT_W'(DEPTH));
        end
    end

`ifdef CDB_ARB_RR_EN
    logic [1:0] rr_q;

    // Walk offsets from far to near so the nearest candidate after the last grant wins.
    always_comb begin
        int idx;
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        idx     = 0;
        for (int off = NUM_SRC; off >= 1; off--) begin
            idx = (int'(rr_q) + off) % NUM_SRC;
            for (int s = 0; s < NUM_SRC; s++) begin
                if (s == idx && cand[s]) begin
                    gnt     = '0;
                    gnt[s]  = 1'b1;
                    gnt_idx = 2'(s);
                    any_gnt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            rr_q <= 2'(NUM_SRC - 1);
        else if (any_gnt)
            rr_q <= gnt_idx;
    end
`else
    // Highest index wins: the multiplier pipe cannot be held, so it drains first.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (cand[i]) begin
                gnt     = '0;
                gnt[i]  = 1'b1;
                gnt_idx = 2'(i);
                any_gnt = 1'b1;
            end
        end
    end
`endif

    // Pop granted head, drop squashed entries, compact, then append the survivor-safe arrival.
    always_comb begin
        int   k;
        pkt_t inc;
        ovf_d = ovf_q;
        k     = 0;
        inc   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            k        = 0;
            inc.data = fu_data[i*XLEN +: XLEN];
            inc.tag  = fu_tag[i*TAG_W +: TAG_W];
            inc.rob  = fu_rob_idx[i*ROB_W +: ROB_W];
            inc.mask = fu_mask[i*MASK_W +: MASK_W] & keep_mask;
            for (int d = 0; d < DEPTH; d++)
                buf_d[i][d] = buf_q[i][d];
            for (int j = 0; j < DEPTH; j++) begin
                if ((j < int'(cnt_q[i])) && !(j == 0 && gnt[i]) &&
                    !killed(squash_valid, squash_mask, buf_q[i][j].mask)) begin
                    for (int d = 0; d < DEPTH; d++) begin
                        if (d == k) begin
                            buf_d[i][d]      = buf_q[i][j];
                            buf_d[i][d].mask = buf_q[i][j].mask & keep_mask;
                        end
                    end
                    k = k + 1;
                end
            end
            if (fu_valid[i]) begin
                if (int'(cnt_q[i]) == DEPTH) begin
                    ovf_d = 1'b1;
                end else if (!killed(squash_valid, squash_mask, fu_mask[i*MASK_W +: MASK_W])) begin
                    for (int d = 0; d < DEPTH; d++) begin
                        if (d == k)
                            buf_d[i][d] = inc;
                    end
                    k = k + 1;
                end
            end
            cnt_d[i] = CNT_W'(k);
        end
    end

    always_comb begin
        cdb_d = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (gnt[i]) begin
                cdb_d      = buf_q[i][0];
                cdb_d.mask = buf_q[i][0].mask & keep_mask;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt_q[i] <= '0;
                for (int d = 0; d < DEPTH; d++)
                    buf_q[i][d] <= '0;
            end
            ovf_q     <= 1'b0;
            cdb_vq    <= 1'b0;
            cdb_q     <= '0;
            cdb_src_q <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt_q[i] <= cnt_d[i];
                for (int d = 0; d < DEPTH; d++)
                    buf_q[i][d] <= buf_d[i][d];
            end
            ovf_q     <= ovf_d;
            cdb_vq    <= any_gnt;
            cdb_q     <= cdb_d;
            cdb_src_q <= gnt_idx;
        end
    end

    // A broadcast already on the bus is still withdrawn by a same-cycle squash.
    assign cdb_valid   = cdb_vq & ~(squash_valid & (|(cdb_q.mask & squash_mask)));
    assign cdb_data    = cdb_q.data;
    assign cdb_tag     = cdb_q.tag;
    assign cdb_rob_idx = cdb_q.rob;
    assign cdb_mask    = cdb_q.mask;
    assign cdb_src     = cdb_src_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed scoreboard bench for cdb_arbiter
module tb_cdb_arbiter;

    localparam int NS = 3;
    localparam int XL = 32;
    localparam int TW = 6;
    localparam int RW = 5;
    localparam int MW = 8;

    typedef logic [52:0] exp_t;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [NS-1:0]   fu_valid;
    logic [NS*XL-1:0] fu_data;
    logic [NS*TW-1:0] fu_tag;
    logic [NS*RW-1:0] fu_rob_idx;
    logic [NS*MW-1:0] fu_mask;
    logic [NS-1:0]   fu_stall;
    logic            squash_valid;
    logic [MW-1:0]   squash_mask;
    logic            resolve_valid;
    logic [MW-1:0]   resolve_mask;
    logic            cdb_valid;
    logic [XL-1:0]   cdb_data;
    logic [TW-1:0]   cdb_tag;
    logic [RW-1:0]   cdb_rob_idx;
    logic [MW-1:0]   cdb_mask;
    logic [1:0]      cdb_src;
    logic            overflow;

    exp_t exp_q[$];
    int   vectors = 0;
    int   errors  = 0;
    logic last_valid = 1'b0;

    cdb_arbiter dut (
        .clock(clock), .reset(reset),
        .fu_valid(fu_valid), .fu_data(fu_data), .fu_tag(fu_tag),
        .fu_rob_idx(fu_rob_idx), .fu_mask(fu_mask), .fu_stall(fu_stall),
        .squash_valid(squash_valid), .squash_mask(squash_mask),
        .resolve_valid(resolve_valid), .resolve_mask(resolve_mask),
        .cdb_valid(cdb_valid), .cdb_data(cdb_data), .cdb_tag(cdb_tag),
        .cdb_rob_idx(cdb_rob_idx), .cdb_mask(cdb_mask), .cdb_src(cdb_src),
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input int s, input logic [31:0] d, input logic [5:0] t,
                                input logic [4:0] r, input logic [7:0] m);
        return {2'(s), m, r, t, d};
    endfunction

    task automatic idle();
        fu_valid = '0; fu_data = '0; fu_tag = '0; fu_rob_idx = '0; fu_mask = '0;
        squash_valid = 1'b0; squash_mask = '0;
        resolve_valid = 1'b0; resolve_mask = '0;
    endtask

    task automatic drive(input int s, input logic [31:0] d, input logic [5:0] t,
                         input logic [4:0] r, input logic [7:0] m);
        fu_valid[s]          = 1'b1;
        fu_data[s*XL +: XL]  = d;
        fu_tag[s*TW +: TW]   = t;
        fu_rob_idx[s*RW +: RW] = r;
        fu_mask[s*MW +: MW]  = m;
    endtask

    // Sample the bus mid-cycle, then advance past the next rising edge.
    task automatic step();
        exp_t got;
        exp_t want;
        @(negedge clock);
        last_valid = cdb_valid;
        if (cdb_valid === 1'b1) begin
            got = {cdb_src, cdb_mask, cdb_rob_idx, cdb_tag, cdb_data};
            chk("cdb_expected_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                chk("cdb_packet", 64'(got), 64'(want));
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input string tag, input int n);
        repeat (n) step();
        chk(tag, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        idle();
        exp_q.delete();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    initial begin
        idle();
        #2;
        chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
        chk("rst_fu_stall", 64'(fu_stall), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_cdb_data", 64'(cdb_data), 64'd0);
        @(posedge clock);
        #1 reset = 1'b1;

        // single ALU packet: two edges from presentation to broadcast
        drive(0, 32'd1000, 6'd5, 5'd3, 8'h80);
        exp_q.push_back(mk(0, 32'd1000, 6'd5, 5'd3, 8'h80));
        step(); chk("lat_c0", 64'(last_valid), 64'd0);
        idle();
        step(); chk("lat_c1", 64'(last_valid), 64'd0);
        step(); chk("lat_c2", 64'(last_valid), 64'd1);
        step(); chk("lat_c3", 64'(last_valid), 64'd0);
        chk("lat_drained", 64'(exp_q.size()), 64'd0);

        // all sources at once right after reset
        do_reset();
        for (int s = 0; s < NS; s++) drive(s, 32'd100 + 32'(s), 6'(10 + s), 5'(s), 8'h00);
`ifdef CDB_ARB_RR_EN
        for (int s = 0; s < NS; s++) exp_q.push_back(mk(s, 32'd100 + 32'(s), 6'(10 + s), 5'(s), 8'h00));
`else
        for (int s = NS - 1; s >= 0; s--) exp_q.push_back(mk(s, 32'd100 + 32'(s), 6'(10 + s), 5'(s), 8'h00));
`endif
        step();
        idle();
        drain("order_drain", 6);

`ifndef CDB_ARB_RR_EN
        // ALU starved by MUL fills, stalls, then drops an arrival
        exp_q.push_back(mk(2, 32'hA0, 6'd20, 5'd0, 8'h00));
        exp_q.push_back(mk(2, 32'hA1, 6'd21, 5'd1, 8'h00));
        exp_q.push_back(mk(0, 32'hB0, 6'd30, 5'd2, 8'h00));
        exp_q.push_back(mk(0, 32'hB1, 6'd31, 5'd3, 8'h00));
        drive(0, 32'hB0, 6'd30, 5'd2, 8'h00); drive(2, 32'hA0, 6'd20, 5'd0, 8'h00);
        step();
        idle();
        drive(0, 32'hB1, 6'd31, 5'd3, 8'h00); drive(2, 32'hA1, 6'd21, 5'd1, 8'h00);
        step();
        chk("stall_full", 64'(fu_stall), 64'h1);
        chk("ovf_before_drop", 64'(overflow), 64'd0);
        idle();
        drive(0, 32'hB2, 6'd32, 5'd4, 8'h00);
        step();
        chk("ovf_after_drop", 64'(overflow), 64'd1);
        chk("stall_held", 64'(fu_stall), 64'h1);
        idle();
        step();
        chk("stall_released", 64'(fu_stall), 64'h0);
        drain("stall_drain", 6);

        // buffered LD entries, squash of 0x80 leaves only the 0x40 one
        exp_q.push_back(mk(2, 32'hC0, 6'd40, 5'd5, 8'h00));
        exp_q.push_back(mk(2, 32'hC1, 6'd41, 5'd6, 8'h00));
        exp_q.push_back(mk(1, 32'hD1, 6'd51, 5'd8, 8'h40));
        drive(1, 32'hD0, 6'd50, 5'd7, 8'h80); drive(2, 32'hC0, 6'd40, 5'd5, 8'h00);
        step();
        idle();
        drive(1, 32'hD1, 6'd51, 5'd8, 8'h40); drive(2, 32'hC1, 6'd41, 5'd6, 8'h00);
        step();
        idle();
        squash_valid = 1'b1; squash_mask = 8'h80;
        drive(0, 32'hE0, 6'd60, 5'd9, 8'h80);
        step();
        idle();
        drain("squash_drain", 6);
        chk("squash_idle_after", 64'(last_valid), 64'd0);
`endif

        // broadcast withdrawn by same-cycle squash; disjoint squash leaves it alone
        drive(0, 32'hF0, 6'd1, 5'd10, 8'hC0);
        step(); idle(); step();
        squash_valid = 1'b1; squash_mask = 8'h40;
        step();
        chk("kill_same_cycle", 64'(last_valid), 64'd0);
        idle();
        step();
        chk("kill_not_rebroadcast", 64'(last_valid), 64'd0);
        drive(0, 32'hF1, 6'd2, 5'd11, 8'hC0);
        exp_q.push_back(mk(0, 32'hF1, 6'd2, 5'd11, 8'hC0));
        step(); idle(); step();
        squash_valid = 1'b1; squash_mask = 8'h01;
        step();
        chk("kill_disjoint_kept", 64'(last_valid), 64'd1);
        idle();
        drain("kill_drain", 3);

`ifndef CDB_ARB_RR_EN
        // resolve clears 0x80 so a later squash of 0x80 spares the entry
        exp_q.push_back(mk(2, 32'h50, 6'd12, 5'd13, 8'h00));
        exp_q.push_back(mk(2, 32'h51, 6'd14, 5'd15, 8'h00));
        exp_q.push_back(mk(0, 32'h40, 6'd16, 5'd17, 8'h40));
        drive(0, 32'h40, 6'd16, 5'd17, 8'hC0); drive(2, 32'h50, 6'd12, 5'd13, 8'h00);
        step();
        idle();
        resolve_valid = 1'b1; resolve_mask = 8'h80;
        drive(2, 32'h51, 6'd14, 5'd15, 8'h20);
        step();
        idle();
        squash_valid = 1'b1; squash_mask = 8'h80;
        resolve_valid = 1'b1; resolve_mask = 8'h20;
        step();
        idle();
        drain("resolve_drain", 6);
`endif

        // asynchronous reset with buffers full
        for (int s = 0; s < NS; s++) drive(s, 32'h70 + 32'(s), 6'd7, 5'd7, 8'h00);
        step();
        idle();
        for (int s = 0; s < NS; s++) drive(s, 32'h78 + 32'(s), 6'd8, 5'd8, 8'h00);
        step();
        idle();
`ifndef CDB_ARB_RR_EN
        chk("pre_rst_stall", 64'(fu_stall), 64'h3);
        chk("pre_rst_overflow", 64'(overflow), 64'd1);
        chk("pre_rst_cdb_src", 64'(cdb_src), 64'd2);
`endif
        chk("pre_rst_cdb_valid", 64'(cdb_valid), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_cdb_valid", 64'(cdb_valid), 64'd0);
        chk("arst_cdb_data", 64'(cdb_data), 64'd0);
        chk("arst_cdb_tag", 64'(cdb_tag), 64'd0);
        chk("arst_cdb_rob", 64'(cdb_rob_idx), 64'd0);
        chk("arst_cdb_mask", 64'(cdb_mask), 64'd0);
        chk("arst_cdb_src", 64'(cdb_src), 64'd0);
        chk("arst_fu_stall", 64'(fu_stall), 64'd0);
        chk("arst_overflow", 64'(overflow), 64'd0);
        exp_q.delete();
        @(posedge clock);
        #1 reset = 1'b1;
        drain("post_rst_quiet", 4);
        chk("post_rst_idle", 64'(last_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
